// File: rtl/sop_pkg.sv
//------------------------------------------------------------------------------
// Module      : sop_pkg
// Description : Shared types and constants for the SOP sequencer slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam int TAPS          = 4;
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_OUT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/sop_valid_pipe.sv
//------------------------------------------------------------------------------
// Module      : sop_valid_pipe
// Description : Token delay line tracking which datapath slots hold full windows.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sop_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tok,
    output logic o_tok,
    output logic o_any_pending
);

    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_tok;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_tok         = r_sr[DEPTH-1];
    assign o_any_pending = |r_sr;

endmodule

`default_nettype wire

// File: rtl/sop_sequencer.sv
//------------------------------------------------------------------------------
// Module      : sop_sequencer
// Description : Coefficient owner and stream sequencer for the 4-tap SOP datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sop_sequencer
    import sop_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int PIPE_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [WIDTH-1:0]     cfg_data,
    output logic                 cfg_err,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     C0,
    output logic [WIDTH-1:0]     C1,
    output logic [WIDTH-1:0]     C2,
    output logic [WIDTH-1:0]     C3,
    output logic [WIDTH-1:0]     DATA_IN,
    output logic                 dp_clr,
    input  logic [OUT_WIDTH-1:0] SUM_OUT,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_sum,
    output logic                 busy
);

    state_t                  r_state;
    logic [1:0]              r_fill_cnt;
    logic [3:0][WIDTH-1:0]   r_coef;
    logic [WIDTH-1:0]        r_data_in;
    logic                    r_out_valid;
    logic [OUT_WIDTH-1:0]    r_out_sum;
    logic                    r_cfg_err;
    logic                    w_tok_in;
    logic                    w_tok_out;
    logic                    w_any_pending;

    // Only samples accepted in RUN complete a full window; FILL samples prime it.
    assign w_tok_in = (r_state == ST_RUN) && in_valid;

    sop_valid_pipe #(
        .DEPTH (PIPE_LAT + 1)
    ) u_valid_pipe (
        .clk           (clk),
        .rst           (rst),
        .i_tok         (w_tok_in),
        .o_tok         (w_tok_out),
        .o_any_pending (w_any_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fill_cnt  <= '0;
            r_coef      <= '0;
            r_data_in   <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err   <= cfg_we && (r_state != ST_IDLE);
            r_out_valid <= w_tok_out;
            r_out_sum   <= SUM_OUT;
            r_data_in   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        r_coef[cfg_addr] <= cfg_data;
                    end
                    if (start) begin
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL, ST_RUN: begin
                    if (in_valid) begin
                        r_data_in <= in_data;
                    end
                    if (r_fill_cnt != 2'(TAPS - 1)) begin
                        r_fill_cnt <= r_fill_cnt + 2'd1;
                    end
                    if (stop) begin
                        r_state <= ST_FLUSH;
                    end else if ((r_state == ST_FILL) && (r_fill_cnt == 2'(TAPS - 2))) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (!w_any_pending) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_fill_cnt <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign C0        = r_coef[0];
    assign C1        = r_coef[1];
    assign C2        = r_coef[2];
    assign C3        = r_coef[3];
    assign DATA_IN   = r_data_in;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign cfg_err   = r_cfg_err;
    assign in_ready  = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign busy      = (r_state != ST_IDLE);
    assign dp_clr    = rst | (r_state == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_sop_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_sop_sequencer
// Description : Self-checking bench with a 4-tap FIR datapath stand-in.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sop_sequencer;

    localparam int WIDTH     = 4;
    localparam int OUT_WIDTH = 8;
    localparam int PIPE_LAT  = 2;
    localparam int TAPS      = 4;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_RUN   = 2;
    localparam int M_FLUSH = 3;
    localparam int M_CLEAR = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_we = 1'b0;
    logic [1:0]           cfg_addr = '0;
    logic [WIDTH-1:0]     cfg_data = '0;
    logic                 cfg_err;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic                 in_valid = 1'b0;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 in_ready;
    logic [WIDTH-1:0]     C0, C1, C2, C3;
    logic [WIDTH-1:0]     DATA_IN;
    logic                 dp_clr;
    logic [OUT_WIDTH-1:0] SUM_OUT;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_sum;
    logic                 busy;

    always #5 clk = ~clk;

    sop_sequencer #(
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .PIPE_LAT  (PIPE_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .start     (start),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .C0        (C0),
        .C1        (C1),
        .C2        (C2),
        .C3        (C3),
        .DATA_IN   (DATA_IN),
        .dp_clr    (dp_clr),
        .SUM_OUT   (SUM_OUT),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    // Datapath stand-in: 4-tap FIR, two register stages (PIPE_LAT = 2).
    logic [WIDTH-1:0]     dp_x0, dp_x1, dp_x2;
    logic [OUT_WIDTH-1:0] dp_s1;
    int                   dp_y;

    always_comb begin
        dp_y = int'(C0) * int'(DATA_IN) + int'(C1) * int'(dp_x0)
             + int'(C2) * int'(dp_x1)   + int'(C3) * int'(dp_x2);
    end

    always @(posedge clk) begin
        if (dp_clr) begin
            dp_x0   <= '0;
            dp_x1   <= '0;
            dp_x2   <= '0;
            dp_s1   <= '0;
            SUM_OUT <= '0;
        end else begin
            dp_x0   <= DATA_IN;
            dp_x1   <= dp_x0;
            dp_x2   <= dp_x1;
            dp_s1   <= dp_y[OUT_WIDTH-1:0];
            SUM_OUT <= dp_s1;
        end
    end

    // Reference model state
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int m_mode = M_IDLE;
    int m_fill = 0;
    int m_coef [4] = '{0, 0, 0, 0};
    int m_hist [$];
    int m_due  [$];
    int m_sum  [$];
    int e_data = 0;
    int e_err  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int fir();
        int s = 0;
        for (int i = 0; i < m_hist.size(); i++) begin
            s += m_coef[i] * m_hist[i];
        end
        return s % 256;
    endfunction

    function automatic int coef_word();
        return m_coef[0] + 16 * m_coef[1] + 256 * m_coef[2] + 4096 * m_coef[3];
    endfunction

    // Advance the model with the current inputs, clock the DUT, compare outputs.
    task automatic step();
        int ev;
        int es;
        e_err  = 0;
        e_data = 0;
        if (rst) begin
            m_mode = M_IDLE;
            m_fill = 0;
            m_coef = '{0, 0, 0, 0};
            m_hist.delete();
            m_due.delete();
            m_sum.delete();
        end else begin
            if (cfg_we && m_mode != M_IDLE) e_err = 1;
            case (m_mode)
                M_IDLE: begin
                    if (cfg_we) m_coef[cfg_addr] = int'(cfg_data);
                    if (start) m_mode = M_FILL;
                end
                M_FILL, M_RUN: begin
                    e_data = in_valid ? int'(in_data) : 0;
                    m_hist.push_front(e_data);
                    if (m_hist.size() > TAPS) void'(m_hist.pop_back());
                    if (m_mode == M_RUN && in_valid) begin
                        m_due.push_back(cyc + 1 + PIPE_LAT + 1);
                        m_sum.push_back(fir());
                    end
                    if (stop) begin
                        m_mode = M_FLUSH;
                    end else if (m_mode == M_FILL) begin
                        m_fill++;
                        if (m_fill == TAPS - 1) m_mode = M_RUN;
                    end
                end
                M_FLUSH: begin
                    if (m_due.size() == 0) m_mode = M_CLEAR;
                end
                default: begin
                    m_mode = M_IDLE;
                    m_fill = 0;
                    m_hist.delete();
                end
            endcase
        end
        @(posedge clk);
        cyc++;
        #1;
        ev = 0;
        es = 0;
        if (m_due.size() != 0 && m_due[0] == cyc) begin
            ev = 1;
            es = m_sum[0];
            void'(m_due.pop_front());
            void'(m_sum.pop_front());
        end
        check("out_valid", int'(out_valid), ev);
        if (ev == 1) check("out_sum", int'(out_sum), es);
        check("DATA_IN", int'(DATA_IN), e_data);
        check("cfg_err", int'(cfg_err), e_err);
        check("in_ready", int'(in_ready), (m_mode == M_FILL || m_mode == M_RUN) ? 1 : 0);
        check("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
        check("dp_clr", int'(dp_clr), (rst || m_mode == M_CLEAR) ? 1 : 0);
        check("coef", int'({C3, C2, C1, C0}), coef_word());
    endtask

    task automatic set_idle();
        rst      = 1'b0;
        cfg_we   = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [3:0] data;
        logic       start;
        logic       stop;
        int         e_coef;
        int         e_err;
        int         e_busy;
        int         e_rdy;
        int         e_clr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int acc [6];
        int ovc [2];
        int ovs [2];
        int n_ov;
        int n_clr;
        int guard;

        // coefficient load, rejected write in RUN, empty stop/flush
        tbl[0]  = '{1'b1, 2'd0, 4'd1,  1'b0, 1'b0, 'h0001, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 2'd1, 4'd2,  1'b0, 1'b0, 'h0021, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 2'd2, 4'd3,  1'b0, 1'b0, 'h0321, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 2'd3, 4'd4,  1'b0, 1'b0, 'h4321, 0, 0, 0, 0};
        tbl[4]  = '{1'b0, 2'd0, 4'd0,  1'b1, 1'b0, 'h4321, 0, 1, 1, 0};
        tbl[5]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 'h4321, 0, 1, 1, 0};
        tbl[6]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 'h4321, 0, 1, 1, 0};
        tbl[7]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 'h4321, 0, 1, 1, 0};
        tbl[8]  = '{1'b1, 2'd2, 4'hF,  1'b0, 1'b0, 'h4321, 1, 1, 1, 0};
        tbl[9]  = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 'h4321, 0, 1, 1, 0};
        tbl[10] = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b1, 'h4321, 0, 1, 0, 0};
        tbl[11] = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 'h4321, 0, 1, 0, 1};
        tbl[12] = '{1'b0, 2'd0, 4'd0,  1'b0, 1'b0, 'h4321, 0, 0, 0, 0};

        rst = 1'b1;
        step();
        step();
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        set_idle();

        for (int i = 0; i < 13; i++) begin
            cfg_we   = tbl[i].we;
            cfg_addr = tbl[i].addr;
            cfg_data = tbl[i].data;
            start    = tbl[i].start;
            stop     = tbl[i].stop;
            step();
            check("tbl_coef",  int'({C3, C2, C1, C0}), tbl[i].e_coef);
            check("tbl_err",   int'(cfg_err),  tbl[i].e_err);
            check("tbl_busy",  int'(busy),     tbl[i].e_busy);
            check("tbl_ready", int'(in_ready), tbl[i].e_rdy);
            check("tbl_clr",   int'(dp_clr),   tbl[i].e_clr);
        end
        set_idle();

        // fill and latency with C = 1,2,3,4
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 4'(k);
            step();
            acc[k] = cyc;
        end
        in_valid = 1'b0;
        ovc = '{-1, -1};
        ovs = '{-1, -1};
        n_ov = 0;
        for (int t = 0; t < 12 && n_ov < 2; t++) begin
            step();
            if (out_valid) begin
                ovc[n_ov] = cyc;
                ovs[n_ov] = int'(out_sum);
                n_ov++;
            end
        end
        check("first_ov_cycle", ovc[0], acc[4] + 3);
        check("first_ov_sum", ovs[0], 20);
        check("second_ov_cycle", ovc[1], acc[5] + 3);
        check("second_ov_sum", ovs[1], 30);

        // one-cycle bubble between samples 6 and 7
        in_valid = 1'b1;
        in_data  = 4'd6;
        step();
        in_valid = 1'b0;
        step();
        check("bubble_data_in", int'(DATA_IN), 0);
        in_valid = 1'b1;
        in_data  = 4'd7;
        step();
        in_valid = 1'b0;
        ovc = '{-1, -1};
        ovs = '{-1, -1};
        n_ov = 0;
        for (int t = 0; t < 12 && n_ov < 2; t++) begin
            step();
            if (out_valid) begin
                ovc[n_ov] = cyc;
                ovs[n_ov] = int'(out_sum);
                n_ov++;
            end
        end
        check("bubble_sum6", ovs[0], 6);
        check("bubble_sum7", ovs[1], 25);
        check("bubble_gap", ovc[1] - ovc[0], 2);

        // stop with two tokens in flight
        in_valid = 1'b1;
        in_data  = 4'd1;
        step();
        in_data  = 4'd2;
        stop     = 1'b1;
        step();
        check("stop_ready", int'(in_ready), 0);
        set_idle();
        n_ov  = 0;
        n_clr = 0;
        guard = 0;
        while (busy && guard < 20) begin
            step();
            if (out_valid) n_ov++;
            if (dp_clr) n_clr++;
            guard++;
        end
        check("flush_ov_count", n_ov, 2);
        check("flush_clr_count", n_clr, 1);
        check("flush_busy", int'(busy), 0);
        check("flush_coef", int'({C3, C2, C1, C0}), 'h4321);

        // reset mid-RUN with tokens pending
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            step();
        end
        rst = 1'b1;
        step();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_coef", int'({C3, C2, C1, C0}), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        set_idle();
        n_ov = 0;
        for (int t = 0; t < 8; t++) begin
            step();
            if (out_valid) n_ov++;
        end
        check("rst_late_ov", n_ov, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_addr = 2'($urandom);
            cfg_data = 4'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
